// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and line levels, used by TX and the planned RX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_param_if.sv
// Word handshake between a producer and the UART transmitter holding register.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  import uart_pkg::*;

  logic [DATA_BITS-1:0] din;
  logic                 din_vld;
  logic                 din_rdy;

  modport master (output din, output din_vld, input  din_rdy);
  modport slave  (input  din, input  din_vld, output din_rdy);

endinterface : uart_tx_param_if

// File: rtl/uart_baud_edge.sv
// Rising-edge detector on the shared baud clock: one clk-wide bedge per bclk period.
module uart_baud_edge (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  output logic bedge
);

  logic was_bclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      was_bclk <= 1'b0;
    end else begin
      was_bclk <= bclk;
    end
  end

  assign bedge = bclk & ~was_bclk;

endmodule : uart_baud_edge

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with one-word holding register and programmable idle gap.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BAUDS  = 30,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bclk,
  uart_tx_param_if.slave tx_if,
  output logic           tx,
  output logic           busy
);

  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam int unsigned SW = $clog2(STOP_BITS + 1);
  localparam int unsigned GW = (GAP_BAUDS == 0) ? 1 : $clog2(GAP_BAUDS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  uart_state_e          state_q, state_d;
  logic                 bedge;
  logic                 start_pt;
  logic                 accept;
  logic [DATA_BITS-1:0] thr_q;
  logic [DATA_BITS-1:0] tsr_q, tsr_d;
  logic                 thr_full_q, thr_full_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic                 tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_baud_edge u_baud_edge (
    .clk   (clk),
    .rst   (rst),
    .bclk  (bclk),
    .bedge (bedge)
  );

  assign accept        = tx_if.din_vld & ~thr_full_q;
  assign tx_if.din_rdy = ~thr_full_q;

  // Points where a new frame may begin: idle, end of stop bits with no gap, end of gap.
  always_comb begin
    start_pt = 1'b0;
    if (bedge) begin
      case (state_q)
        IDLE:    start_pt = 1'b1;
        STOP:    start_pt = (scnt_q == SW'(STOP_BITS)) && (GAP_BAUDS == 0);
        GAP:     start_pt = (gcnt_q == GW'(GAP_BAUDS));
        default: start_pt = 1'b0;
      endcase
    end
  end

  // State register together with the datapath it sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx         <= STOP_BIT;
      busy       <= 1'b0;
      thr_q      <= '0;
      tsr_q      <= '0;
      thr_full_q <= 1'b0;
      cnt_q      <= '0;
      scnt_q     <= '0;
      gcnt_q     <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx         <= tx_d;
      busy       <= (state_d != IDLE) | thr_full_d;
      tsr_q      <= tsr_d;
      thr_full_q <= thr_full_d;
      cnt_q      <= cnt_d;
      scnt_q     <= scnt_d;
      gcnt_q     <= gcnt_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
      if (accept) begin
        thr_q <= tx_if.din;
      end
    end
  end

  // Next-state logic; the state name is the bit currently on the line.
  always_comb begin
    state_d = state_q;
    if (start_pt) begin
      state_d = thr_full_q ? START : IDLE;
    end else if (bedge) begin
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          if (cnt_q == CW'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: begin
          if (scnt_q == SW'(STOP_BITS)) begin
            state_d = GAP;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Line value, shifter, counters and holding-register flag.
  always_comb begin
    tx_d       = tx;
    tsr_d      = tsr_q;
    cnt_d      = cnt_q;
    scnt_d     = scnt_q;
    gcnt_d     = gcnt_q;
    thr_full_d = thr_full_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    if (accept) begin
      thr_full_d = 1'b1;
    end

    if (start_pt) begin
      if (thr_full_q) begin
        tsr_d      = thr_q;
        thr_full_d = 1'b0;
        tx_d       = START_BIT;
`ifdef UART_TX_PARITY_EN
        par_d      = (PARITY_ODD != 0) ? ~^thr_q : ^thr_q;
`endif
      end else begin
        tx_d = STOP_BIT;
      end
    end else if (bedge) begin
      case (state_q)
        START: begin
          tx_d  = tsr_q[0];
          tsr_d = tsr_q >> 1;
          cnt_d = CW'(1);
        end
        DATA: begin
          if (cnt_q != CW'(DATA_BITS)) begin
            tx_d  = tsr_q[0];
            tsr_d = tsr_q >> 1;
            cnt_d = cnt_q + CW'(1);
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d   = par_q;
`else
            tx_d   = STOP_BIT;
            scnt_d = SW'(1);
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_d   = STOP_BIT;
          scnt_d = SW'(1);
        end
`endif
        STOP: begin
          if (scnt_q != SW'(STOP_BITS)) begin
            scnt_d = scnt_q + SW'(1);
          end else begin
            gcnt_d = GW'(1);
          end
        end
        GAP: begin
          tx_d   = STOP_BIT;
          gcnt_d = gcnt_q + GW'(1);
        end
        default: tx_d = tx;
      endcase
    end
  end

endmodule : uart_tx_param

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three configurations driven side by side, one sample per baud.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  localparam int N_SLOTS = 46;
  localparam int B0 = 41 + P;       // u0 busy falls (GAP 30)
  localparam int B1 = 25 + 2 * P;   // u1 busy falls (GAP 2)
  localparam int B2 = 21 + 2 * P;   // u2 busy falls (GAP 0)
  localparam int S1 = 13 + P;       // u1 second start bit
  localparam int S2 = 11 + P;       // u2 second start bit

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] phase = 2'd0;
  logic       bclk;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;

  int    n_chk  = 0;
  int    n_fail = 0;
  string e0, e1, e2, er;

  always #5 clk = ~clk;
  always @(posedge clk) phase <= phase + 2'd1;
  // bclk high for two clk cycles per period, so a missed edge-detect shows up as extra bits.
  assign bclk = (phase == 2'd0) || (phase == 2'd1);

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(7)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .GAP_BAUDS(30), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .bclk(bclk), .tx_if(if0), .tx(tx0), .busy(busy0));
  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .GAP_BAUDS(2), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .bclk(bclk), .tx_if(if1), .tx(tx1), .busy(busy1));
  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .GAP_BAUDS(0), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .bclk(bclk), .tx_if(if2), .tx(tx2), .busy(busy2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_at(input string s, input int i);
    if (i < 0 || i >= s.len()) return 1'b1;
    return s.getc(i) == 8'h31;
  endfunction

  // Negedge inside the clk cycle two after the baud edge: the bit for this baud is settled.
  task automatic wait_slot();
    do @(negedge clk); while (phase != 2'd2);
  endtask

  initial begin
    if0.din = '0; if0.din_vld = 1'b0;
    if1.din = '0; if1.din_vld = 1'b0;
    if2.din = '0; if2.din_vld = 1'b0;

`ifdef UART_TX_PARITY_EN
    e0 = {"1", "01010010101"};
    e1 = {"1", "00000000111", "11", "01010101111"};
    e2 = {"1", "00011110011", "01010010111"};
    er = "01111000001";
`else
    e0 = {"1", "0101001011"};
    e1 = {"1", "0000000011", "11", "0101010111"};
    e2 = {"1", "0001111001", "0101001011"};
    er = "0111100001";
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx0", 32'(tx0), 32'd1);
    chk("rst_tx1", 32'(tx1), 32'd1);
    chk("rst_rdy0", 32'(if0.din_rdy), 32'd1);
    chk("rst_rdy2", 32'(if2.din_rdy), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    for (int s = 0; s < N_SLOTS; s++) begin
      wait_slot();
      chk($sformatf("tx0[%0d]", s), 32'(tx0), 32'(exp_at(e0, s)));
      chk($sformatf("tx1[%0d]", s), 32'(tx1), 32'(exp_at(e1, s)));
      chk($sformatf("tx2[%0d]", s), 32'(tx2), 32'(exp_at(e2, s)));
      chk($sformatf("busy0[%0d]", s), 32'(busy0), 32'(s >= 1 && s < B0));
      chk($sformatf("busy1[%0d]", s), 32'(busy1), 32'(s >= 1 && s < B1));
      chk($sformatf("busy2[%0d]", s), 32'(busy2), 32'(s >= 1 && s < B2));
      chk($sformatf("rdy0[%0d]", s), 32'(if0.din_rdy), 32'd1);
      chk($sformatf("rdy1[%0d]", s), 32'(if1.din_rdy), 32'(!(s >= 4 && s < S1)));
      chk($sformatf("rdy2[%0d]", s), 32'(if2.din_rdy), 32'(!(s >= 3 && s < S2)));

      if (s == 0) begin
        if0.din = 8'hA5; if0.din_vld = 1'b1;
        if1.din = 7'h00; if1.din_vld = 1'b1;
        if2.din = 8'h3C; if2.din_vld = 1'b1;
      end
      if (s == 2) begin if2.din = 8'hA5; if2.din_vld = 1'b1; end
      if (s == 3) begin if1.din = 7'h55; if1.din_vld = 1'b1; end
      // Presented while the holding register is full: must be ignored.
      if (s == 5) begin if1.din = 7'h7F; if1.din_vld = 1'b1; end

      @(negedge clk);
      if (s == 0) begin
        chk("rdy0_after_accept", 32'(if0.din_rdy), 32'd0);
        chk("busy0_after_accept", 32'(busy0), 32'd1);
      end
      if0.din_vld = 1'b0;
      if1.din_vld = 1'b0;
      if2.din_vld = 1'b0;
    end

    // Reset in the middle of data bit 3, with a second word held.
    wait_slot();
    if0.din = 8'hA5; if0.din_vld = 1'b1;
    @(negedge clk);
    if0.din_vld = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_slot();
      chk($sformatf("pre_rst_tx0[%0d]", k), 32'(tx0), 32'(exp_at("01010", k - 1)));
      if (k == 2) begin
        if0.din = 8'hFF; if0.din_vld = 1'b1;
        @(negedge clk);
        if0.din_vld = 1'b0;
      end
      if (k == 3) chk("held_rdy0", 32'(if0.din_rdy), 32'd0);
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx0", 32'(tx0), 32'd1);
    chk("mid_rst_rdy0", 32'(if0.din_rdy), 32'd1);
    chk("mid_rst_busy0", 32'(busy0), 32'd0);
    #1 rst = 1'b0;

    wait_slot();
    chk("post_rst_idle_tx0", 32'(tx0), 32'd1);
    if0.din = 8'h0F; if0.din_vld = 1'b1;
    @(negedge clk);
    if0.din_vld = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wait_slot();
      chk($sformatf("post_rst_tx0[%0d]", k), 32'(tx0), 32'(exp_at(er, k - 1)));
    end
    chk("post_rst_busy0_in_gap", 32'(busy0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_param

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter for the UART controller. It serialises words of 5–9 bits, LSB first, framed by one start bit and 1 or 2 stop bits, with an optional parity bit. Bit timing comes from the shared baud clock `bclk`. A programmable idle gap separates frames. A one-word holding register with a valid/ready handshake lets the next word load while the current frame shifts out.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `GAP_BAUDS`, default 30: minimum idle baud periods between consecutive frames; 0 is legal.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when `UART_TX_PARITY_EN` is defined.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `bclk` in 1: baud clock, synchronous to `clk` and high for at least one `clk` cycle per period.
- `din` in DATA_BITS: word to send.
- `din_vld` in 1: `din` is valid.
- `din_rdy` out 1: holding register is empty.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: high while a frame is in flight or a word is held.

## Operation
- Baud edge (`bedge`): the `clk` cycle in which `bclk`=1 and the registered `was_bclk`=0. Every line change and every state transition happens on a `bedge` cycle.
- Handshake:
  - A word transfers on a `clk` edge where `din_vld` & `din_rdy` are both high; `din` is copied into `thr` and `thr_full` is set.
  - `din_rdy` = !`thr_full`.
  - `din` is ignored whenever `din_rdy`=0.
- Start decision, taken in IDLE on a `bedge` and at the end of a gap:
  - If `thr_full`: load `tsr`←`thr`, compute parity, clear `thr_full`, drive `tx`=0, go to START.
  - Otherwise stay in IDLE with `tx`=1.
- State transitions, one per `bedge`. Each state name is the bit currently on the line.
  - START: drive `tsr[0]`, shift right, `cnt`←1, go to DATA.
  - DATA, `cnt` < `DATA_BITS`: drive `tsr[0]`, shift, `cnt`++.
  - DATA, `cnt` = `DATA_BITS`: drive the parity bit and go to PARITY if enabled; otherwise drive 1, `scnt`←1, go to STOP.
  - PARITY: drive 1, `scnt`←1, go to STOP.
  - STOP, `scnt` < `STOP_BITS`: `scnt`++, `tx` stays 1.
  - STOP, `scnt` = `STOP_BITS`, `GAP_BAUDS`=0: take the start decision immediately.
  - STOP, `scnt` = `STOP_BITS`, `GAP_BAUDS`>0: go to GAP, `gcnt`←1.
  - GAP: `tx`=1. If `gcnt` = `GAP_BAUDS`, take the start decision; else `gcnt`++.
- `busy` = (state ≠ IDLE) | `thr_full`.
- Counter widths:
  - `cnt`: $clog2(DATA_BITS+1).
  - `gcnt`: max(1, $clog2(GAP_BAUDS+1)).
  - No counter may wrap inside its legal range.

## Timing
- Reset values: `tx`=1, `din_rdy`=1, `busy`=0, state IDLE, `was_bclk`=0, `thr_full`=0, all counters 0.
- Reset mid-frame: `tx` returns to 1 asynchronously; the frame being shifted and any held word are discarded.
- `din_rdy` falls on the `clk` edge after acceptance. It rises on the `clk` edge following the `bedge` that moves `thr` into `tsr`.
- Latency: a word accepted while IDLE drives its start bit at the next `bedge` strictly after acceptance. Acceptance in the same cycle as a `bedge` waits for the following `bedge`.
- Each bit lasts exactly one `bclk` period.
- Frame length in baud periods is 1 + `DATA_BITS` + parity (0 or 1) + `STOP_BITS`.
- Back-to-back words: the line stays high for exactly `GAP_BAUDS` baud periods between the end of the last stop bit and the next start bit.
- `bclk` held high does not produce repeated `bedge` events.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present.
  - Parity = ^data when `PARITY_ODD`=0, ~^data when `PARITY_ODD`=1.
  - Parity is computed on `tsr` load.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; `PARITY_ODD` is ignored; DATA goes directly to STOP.

## Structure
- Package `uart_pkg`: state encoding (IDLE, START, DATA, PARITY, STOP, GAP), `START_BIT`=0, `STOP_BIT`=1. The future RX successor shares this package.
- Sub-module `uart_baud_edge`: registers `bclk` into `was_bclk` and outputs the one-cycle `bedge` pulse.

## Test plan
- `DATA_BITS`=8, no parity, `din`=0xA5 → per baud: 0, 1, 0, 1, 0, 0, 1, 0, 1, then 1 (stop); `busy` falls after the gap.
- Parity enabled, `din`=0xA5:
  - `PARITY_ODD`=0 → parity bit 0.
  - `PARITY_ODD`=1 → parity bit 1.
  - In both cases the stop bit follows.
- `DATA_BITS`=7, `STOP_BITS`=2, `din`=0x00 → 0, seven 0s, then 1, 1; frame is 10 baud periods.
- `GAP_BAUDS`=2, second word presented during the first frame:
  - `din_rdy` stays 0 from the second acceptance until the second frame loads.
  - Exactly 2 high baud periods separate the two frames.
- `GAP_BAUDS`=0, back-to-back words → start bit immediately follows the last stop bit.
- `rst` pulsed during data bit 3 → `tx`=1 and `din_rdy`=1 at once; the next accepted word sends a clean full frame.
